// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: add/sub, shift-add multiply, restoring divide, one request in flight.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise op 11 returns an error response.
module alu_sequencer #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  input  logic [1:0]     req_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_data,
  output logic [W-1:0]   rsp_rem,
  output logic           rsp_err,
  output logic           busy
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    IDLE, ADDSUB, MUL, DONE
`ifdef ALU_SEQ_DIV_EN
    , DIV
`endif
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_q, b_q, rem_q;
  logic           sub_q, err_q;
  logic [2*W-1:0] acc;
  logic           last;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign rsp_data  = acc;
  assign rsp_rem   = rem_q;
  assign rsp_err   = err_q;
  assign last      = (cnt == CW'(W - 1));

  // acc = {partial product, remaining multiplier bits}; shifts right once per step
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_nxt;
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_q} : '0);
    mul_nxt = {mul_sum, acc[W-1:1]};
  end

`ifdef ALU_SEQ_DIV_EN
  // a_q shifts dividend bits out the top and quotient bits in the bottom
  logic [W:0]   div_sh;
  logic         div_ge;
  logic [W-1:0] div_rem_nxt, div_quo_nxt;
  always_comb begin
    div_sh      = {rem_q, a_q[W-1]};
    div_ge      = (div_sh >= {1'b0, b_q});
    div_rem_nxt = div_ge ? W'(div_sh - {1'b0, b_q}) : div_sh[W-1:0];
    div_quo_nxt = {a_q[W-2:0], div_ge};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            2'b00, 2'b01: state_nxt = ADDSUB;
            2'b10:        state_nxt = MUL;
`ifdef ALU_SEQ_DIV_EN
            default:      state_nxt = (req_b == '0) ? DONE : DIV;
`else
            default:      state_nxt = DONE;
`endif
          endcase
        end
      end
      ADDSUB: state_nxt = DONE;
      MUL:    if (last) state_nxt = DONE;
`ifdef ALU_SEQ_DIV_EN
      DIV:    if (last) state_nxt = DONE;
`endif
      DONE:   if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      acc   <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cnt   <= '0;
            a_q   <= req_a;
            b_q   <= req_b;
            sub_q <= req_op[0];
            rem_q <= '0;
            err_q <= 1'b0;
            acc   <= '0;
            if (req_op == 2'b10) acc <= {{W{1'b0}}, req_b};
            if (req_op == 2'b11) begin
`ifdef ALU_SEQ_DIV_EN
              if (req_b == '0) begin
                acc   <= '1;
                err_q <= 1'b1;
              end
`else
              err_q <= 1'b1;
`endif
            end
          end
        end
        ADDSUB: begin
          if (sub_q) acc <= {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
          else       acc <= {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
        end
        MUL: begin
          cnt <= cnt + CW'(1);
          acc <= mul_nxt;
        end
`ifdef ALU_SEQ_DIV_EN
        DIV: begin
          cnt   <= cnt + CW'(1);
          rem_q <= div_rem_nxt;
          a_q   <= div_quo_nxt;
          acc   <= {{W{1'b0}}, div_quo_nxt};
        end
`endif
        default: ;
      endcase
    end
  end
endmodule
